// File: rtl/ctu_arb.sv
// ctu_arb: round-robin write bursts and on-demand pop bursts into one CTU; grant 1 cycle after IDLE, pop data 1 cycle after ctu_rd.
// Backpressure: never writes while ctu_full or reads while ctu_empty. Define CTU_ARB_RD_PRIORITY_EN to favour pops in IDLE.
module ctu_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_WD   = 11,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       pop_req,
  output logic                       pop_valid,
  output logic [DATA_WD-1:0]         pop_data,
  output logic                       ctu_cs,
  output logic                       ctu_wr,
  output logic                       ctu_rd,
  output logic [DATA_WD-1:0]         ctu_EV_in,
  input  logic [DATA_WD-1:0]         ctu_EV_out,
  input  logic                       ctu_full,
  input  logic                       ctu_empty,
  output logic                       busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_SETTLE, S_RD} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pop_valid_q, pop_valid_d;
  logic [DATA_WD-1:0] pop_data_q, pop_data_d;

  logic             wr_ok, rd_ok, burst_done;
  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx, scan_idx;

  assign wr_ok      = (|req_valid) && !ctu_full;
  assign rd_ok      = pop_req && !ctu_empty;
  assign burst_done = (cnt_q == CNT_W'(MAX_BURST));

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data_q;
    req_ready   = '0;
    ctu_cs      = 1'b0;
    ctu_wr      = 1'b0;
    ctu_rd      = 1'b0;
    ctu_EV_in   = '0;
    unique case (state_q)
      S_IDLE: begin
`ifdef CTU_ARB_RD_PRIORITY_EN
        if (rd_ok) begin
          state_d = S_RD;
          cnt_d   = '0;
        end else if (wr_ok) begin
          state_d = S_WR;
          cnt_d   = '0;
        end
`else
        if (wr_ok) begin
          state_d = S_WR;
          cnt_d   = '0;
        end else if (rd_ok) begin
          state_d = S_RD;
          cnt_d   = '0;
        end
`endif
      end
      S_WR: begin
        // The cycle that fails the test is the no-grant exit cycle before SETTLE.
        if (wr_ok && gnt_found && !burst_done) begin
          req_ready[gnt_idx] = 1'b1;
          ctu_wr             = 1'b1;
          ctu_cs             = 1'b1;
          ctu_EV_in          = req_data[gnt_idx*DATA_WD +: DATA_WD];
          rr_ptr_d           = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d              = cnt_q + 1'b1;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_IDLE;
      S_RD: begin
        if (rd_ok && !burst_done) begin
          ctu_rd      = 1'b1;
          ctu_cs      = 1'b1;
          pop_valid_d = 1'b1;
          pop_data_d  = ctu_EV_out;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ctu_arb.sv
// Bench for ctu_arb: sorted-set CTU model, per-producer entry lists, grant/pop scoreboards.
module tb_ctu_arb;
  localparam int NR = 4;
  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             pop_req, pop_valid;
  logic [DW-1:0]    pop_data;
  logic             ctu_cs, ctu_wr, ctu_rd;
  logic [DW-1:0]    ctu_EV_in, ctu_EV_out;
  logic             ctu_full, ctu_empty;
  logic             busy;

  ctu_arb #(.NUM_REQ(NR), .DATA_WD(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .ctu_cs(ctu_cs), .ctu_wr(ctu_wr), .ctu_rd(ctu_rd),
    .ctu_EV_in(ctu_EV_in), .ctu_EV_out(ctu_EV_out),
    .ctu_full(ctu_full), .ctu_empty(ctu_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // CTU model: sorted set, head is the smallest entry.
  logic [DW-1:0] cmem [0:63];
  int cn = 0;
  int cap = 64;

  // Producers: per-producer entry lists with head/tail indices.
  logic [DW-1:0] pmem [0:NR-1][0:7];
  int phd [0:NR-1];
  int ptl [0:NR-1];
  int pops_wanted = 0;

  int exp_gnt[$];
  logic [DW-1:0] exp_pop[$];
  int gnt_cyc[$];
  bit busy_log [0:4095];
  bit cs_log [0:4095];
  bit prev_rd = 1'b0;
  int first_wr = -1;
  int first_rd = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_ins(input logic [DW-1:0] v);
    int pos;
    pos = cn;
    for (int i = 0; i < cn; i++) if (cmem[i] == v) return;
    for (int i = 0; i < cn; i++) if (cmem[i] > v && pos == cn) pos = i;
    for (int i = cn; i > pos; i--) cmem[i] = cmem[i-1];
    cmem[pos] = v;
    cn++;
  endtask

  task automatic model_drive();
    ctu_full   = (cn >= cap);
    ctu_empty  = (cn == 0);
    ctu_EV_out = (cn > 0) ? cmem[0] : '0;
  endtask

  task automatic add_ent(input int p, input logic [DW-1:0] v);
    pmem[p][ptl[p]] = v;
    ptl[p]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (phd[i] < ptl[i]);
      req_data[i*DW +: DW] = (phd[i] < ptl[i]) ? pmem[i][phd[i]] : '0;
    end
    pop_req = (pops_wanted > 0);
  endtask

  // One clock: sample/check at negedge, advance models just after posedge.
  task automatic tick();
    logic s_wr, s_rd, s_pv;
    logic [DW-1:0] s_ev, s_pd;
    int g;
    @(negedge clk);
    s_wr = ctu_wr; s_rd = ctu_rd; s_ev = ctu_EV_in; s_pv = pop_valid; s_pd = pop_data;
    busy_log[cyc] = busy;
    cs_log[cyc]   = ctu_cs;
    g = -1;
    for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
    if (s_wr || s_rd) begin
      chk("wr_rd_excl", s_wr & s_rd, 0);
      if (s_wr) chk("wr_while_full", ctu_full, 0);
      if (s_rd) chk("rd_while_empty", ctu_empty, 0);
    end
    if (req_ready != '0) begin
      chk("gnt_onehot", $countones(req_ready), 1);
      chk("gnt_has_wr", s_wr, 1);
      chk("gnt_expected", exp_gnt.size() > 0, 1);
      if (exp_gnt.size() > 0) chk("gnt_idx", g, exp_gnt.pop_front());
      chk("gnt_data", s_ev, pmem[g][phd[g]]);
      gnt_cyc.push_back(cyc);
    end else if (s_wr) begin
      chk("wr_without_gnt", s_wr, 0);
    end
    if (s_pv) begin
      chk("pop_latency", prev_rd, 1);
      chk("pop_expected", exp_pop.size() > 0, 1);
      if (exp_pop.size() > 0) chk("pop_data", s_pd, exp_pop.pop_front());
    end
    if (s_wr && first_wr < 0) first_wr = cyc;
    if (s_rd && first_rd < 0) first_rd = cyc;
    @(posedge clk);
    #1;
    if (s_rd && cn > 0) begin
      for (int i = 0; i < cn - 1; i++) cmem[i] = cmem[i+1];
      cn--;
    end
    if (s_wr) model_ins(s_ev);
    if (g >= 0) phd[g]++;
    if (s_rd && pops_wanted > 0) pops_wanted--;
    prev_rd = s_rd;
    model_drive();
    drive_reqs();
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_ctu_cs", ctu_cs, 0);
    cn = 0;
    for (int i = 0; i < NR; i++) begin
      phd[i] = 0;
      ptl[i] = 0;
    end
    pops_wanted = 0;
    prev_rd = 1'b0;
    exp_gnt.delete();
    exp_pop.delete();
    gnt_cyc.delete();
    model_drive();
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic end_chk(input string tag);
    chk({tag, "_gnt_left"}, exp_gnt.size(), 0);
    chk({tag, "_pop_left"}, exp_pop.size(), 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      phd[i] = 0;
      ptl[i] = 0;
    end
    model_drive();
    drive_reqs();

    // Single producer 5, 9, 5 then two pops.
    do_reset();
    add_ent(0, 11'd5); add_ent(0, 11'd9); add_ent(0, 11'd5);
    repeat (3) exp_gnt.push_back(0);
    drive_reqs();
    t0 = cyc;
    repeat (8) tick();
    chk("t1_gnt_count", gnt_cyc.size(), 3);
    chk("t1_gnt_latency", gnt_cyc[0] - t0, 1);
    chk("t1_b2b_a", gnt_cyc[1] - gnt_cyc[0], 1);
    chk("t1_b2b_b", gnt_cyc[2] - gnt_cyc[1], 1);
    chk("t1_settle_busy", busy_log[gnt_cyc[2] + 2], 1);
    chk("t1_settle_cs", cs_log[gnt_cyc[2] + 2], 0);
    chk("t1_idle_after", busy_log[gnt_cyc[2] + 3], 0);
    exp_pop.push_back(11'd5);
    exp_pop.push_back(11'd9);
    pops_wanted = 2;
    drive_reqs();
    repeat (8) tick();
    chk("t1_empty_after", ctu_empty, 1);
    end_chk("t1");

    // All producers valid: 0,1,2,3,0,1,2,3 | settle | 0,1,2,3.
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) begin
        add_ent(i, 11'(100 + 4*k + i));
        exp_gnt.push_back(i);
      end
    drive_reqs();
    repeat (24) tick();
    chk("t2_gnt_count", gnt_cyc.size(), 12);
    chk("t2_burst_span", gnt_cyc[7] - gnt_cyc[0], 7);
    chk("t2_burst_gap", gnt_cyc[8] - gnt_cyc[7], 4);
    chk("t2_gap_idle", busy_log[gnt_cyc[7] + 3], 0);
    end_chk("t2");

    // CTU full after 3 writes; one pop lets one more write in.
    do_reset();
    cap = 3;
    model_drive();
    for (int i = 0; i < NR; i++) begin
      add_ent(i, 11'(10 + i));
      add_ent(i, 11'(20 + i));
    end
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    drive_reqs();
    repeat (12) tick();
    chk("t3_full", ctu_full, 1);
    chk("t3_idle_wait", busy, 0);
    chk("t3_gnt_count", gnt_cyc.size(), 3);
    exp_pop.push_back(11'd10);
    exp_gnt.push_back(3);
    pops_wanted = 1;
    drive_reqs();
    repeat (12) tick();
    chk("t3_gnt_total", gnt_cyc.size(), 4);
    chk("t3_full_again", ctu_full, 1);
    end_chk("t3");
    cap = 64;

    // pop_req and req_valid together in IDLE.
    do_reset();
    add_ent(0, 11'd7);
    exp_gnt.push_back(0);
    drive_reqs();
    repeat (6) tick();
    first_wr = -1;
    first_rd = -1;
    add_ent(1, 11'd3);
    exp_gnt.push_back(1);
`ifdef CTU_ARB_RD_PRIORITY_EN
    exp_pop.push_back(11'd7);
`else
    exp_pop.push_back(11'd3);
`endif
    pops_wanted = 1;
    drive_reqs();
    repeat (14) tick();
    chk("t4_saw_wr", first_wr >= 0, 1);
    chk("t4_saw_rd", first_rd >= 0, 1);
`ifdef CTU_ARB_RD_PRIORITY_EN
    chk("t4_rd_first", first_rd < first_wr, 1);
`else
    chk("t4_wr_first", first_wr < first_rd, 1);
`endif
    end_chk("t4");

    // Asynchronous reset in cycle 3 of a write burst.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      add_ent(i, 11'(30 + i));
      add_ent(i, 11'(34 + i));
    end
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    drive_reqs();
    repeat (3) tick();
    #2;
    chk("t5_pre_rst_gnt", req_ready, 4'b0100);
    rst = 1'b1;
    #1;
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_ctu_wr", ctu_wr, 0);
    chk("t5_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_rd = 1'b0;
    @(posedge clk);
    #1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    exp_gnt.push_back(3); exp_gnt.push_back(2); exp_gnt.push_back(3);
    repeat (16) tick();
    end_chk("t5");

    // pop_req against an empty CTU.
    do_reset();
    pops_wanted = 100;
    drive_reqs();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_busy", busy, 0);
      chk("t6_ctu_rd", ctu_rd, 0);
      chk("t6_pop_valid", pop_valid, 0);
    end
    pops_wanted = 0;
    drive_reqs();
    end_chk("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
